seg7_to_bin_seq: RTL and testbench
==================================

Name: seg7_to_bin_seq

Overview:
Reverse path of the 3-digit display chain. Accepts three active-low 7-segment patterns (hundreds/tens/ones), decodes each to a BCD digit, then converts 000–999 to binary with a sequential reverse double-dabble (one shift per clock). Start/busy/done handshake. Used by panel-readback and self-check logic to recover the numeric value driven onto the HEX displays.

Parameters:
SEG_ON, 1'b0, logic level that lights a segment; patterns are compared after XOR with ~SEG_ON so that decoding is polarity-independent.
BIN_W, 10, output width; fixed at 10, which is enough for 999. Any other value is unsupported.

Ports:
clk  input  1  sole clock, rising edge.
reset  input  1  synchronous, active-high.
start  input  1  request a conversion; sampled only in IDLE.
seg_hundreds  input  7  segment pattern, hundreds digit.
seg_tens  input  7  segment pattern, tens digit.
seg_ones  input  7  segment pattern, ones digit.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse; result valid.
bin_out  output  10  converted value; held until the next done.
ovf8  output  1  bin_out > 255; registered with bin_out.
err  output  1  at least one pattern was not a legal digit; registered with bin_out.

Behaviour:
- Segment bit map: bit0 top, bit1 upper-right, bit2 lower-right, bit3 bottom, bit4 lower-left, bit5 upper-left, bit6 middle.
- Legal patterns, shown with SEG_ON=0 and written bit6..bit0:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000
  - Any other pattern is invalid.
- Reset: state=IDLE, busy=0, done=0, bin_out=0, ovf8=0, err=0, iteration counter=0, internal shift register=0.
- States:
  - IDLE: start=1 captures and decodes all three patterns at the same edge (E0).
    - All three valid: load the 22-bit shift register with {h,t,o,10'b0}, counter=0, go to SHIFT. busy=1 from the cycle after E0.
    - Any invalid: go to DONE with result 0 and err=1. busy stays 0. This is a one-cycle path.
  - SHIFT: each edge shifts the 22-bit register right by 1. After the shift, every 4-bit BCD nibble that is >=8 has 3 subtracted. Counter increments.
    - On the 10th shift (edge E10): bin_out <= low 10 bits, ovf8 <= (value > 255), err <= 0, go to DONE.
  - DONE: done=1 and busy=0 for exactly this cycle. Next edge goes to IDLE.
- Latency: done is high in the cycle following E10, i.e. 11 cycles after the start edge. The error path pulses done in the cycle after E0.
- start outside IDLE (SHIFT or DONE) is ignored; no queuing. With start held high continuously, a new conversion is accepted every 12 cycles.
- Input patterns are sampled only at E0. Changes during SHIFT have no effect.
- bin_out, ovf8 and err change only on the edge that enters DONE. They are stable at all other times.
- Reset mid-conversion: returns to IDLE next edge and all outputs clear. No done pulse is produced for the aborted conversion.
- The BCD nibbles reach 0 after the 10th shift for every legal input. Implementation carries an assertion for this (simulation only).

Decomposition:
- Shared include seg7_defs.vh holds:
  - the 10 segment-pattern localparams (SEG_ON=0 form);
  - state encodings IDLE/SHIFT/DONE;
  - BIN_W and the iteration count of 10.
  The existing display encoder is switched to the same include so both ends share one table.
- One sub-module, seg7_decode: combinational 7-bit pattern -> 4-bit digit plus valid, parameterised by SEG_ON. It is instantiated three times. The FSM and datapath stay in seg7_to_bin_seq.

Test Plan:
1. Reset, then patterns "255" (0100100, 0010010, 0010010) with a 1-cycle start -> busy for cycles 1–10, done in cycle 11; bin_out=255, ovf8=0, err=0.
2. "999" (0011000 ×3) -> bin_out=999 (10'h3E7), ovf8=1, err=0. Then "000" (1000000 ×3) -> bin_out=0, ovf8=0.
3. Tens pattern 1111111 (blank), others "1" -> done in the cycle after start; busy never high; bin_out=0, err=1.
4. Pulse start again at cycles 3 and 10 of a "128" conversion, and change the inputs mid-run -> result still 128 at cycle 11; exactly one done.
5. Assert reset at cycle 5 of a "742" conversion -> next cycle busy=0, bin_out=0, no done. A fresh "742" then yields bin_out=742, ovf8=1.
6. Sweep all 1000 legal triples, start held high -> each done spaced 12 cycles apart; bin_out equals 100h+10t+o for every triple.

Source files
------------

// File: rtl/seg7_to_bin_seq_pkg.sv
// Shared definitions for the 7-segment readback path: digit pattern table,
// FSM state encoding, widths and the BCD correction step.
package seg7_to_bin_seq_pkg;

    localparam int BIN_WIDTH = 10;
    localparam int ITERS     = 10;
    localparam int BCD_W     = 12;
    localparam int SHIFT_W   = BCD_W + BIN_WIDTH;

    // Patterns in SEG_ON=0 form, bit6 (middle) .. bit0 (top).
    localparam logic [6:0] SEG_D0 = 7'b1000000;
    localparam logic [6:0] SEG_D1 = 7'b1111001;
    localparam logic [6:0] SEG_D2 = 7'b0100100;
    localparam logic [6:0] SEG_D3 = 7'b0110000;
    localparam logic [6:0] SEG_D4 = 7'b0011001;
    localparam logic [6:0] SEG_D5 = 7'b0010010;
    localparam logic [6:0] SEG_D6 = 7'b0000010;
    localparam logic [6:0] SEG_D7 = 7'b1111000;
    localparam logic [6:0] SEG_D8 = 7'b0000000;
    localparam logic [6:0] SEG_D9 = 7'b0011000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Reverse double-dabble correction: any nibble that reached 8+ after the
    // right shift carried a 10 down from the digit above, so remove the excess.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (r[i*4 +: 4] >= 4'd8) begin
                r[i*4 +: 4] = r[i*4 +: 4] - 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to BCD digit decoder with a legality flag.
module seg7_decode
    import seg7_to_bin_seq_pkg::*;
#(
    parameter logic SEG_ON = 1'b0
) (
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       valid
);

    // Lit segments read as 1 regardless of the panel's drive polarity.
    logic [6:0] lit;
    assign lit = seg ^ {7{~SEG_ON}};

    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        case (lit)
            ~SEG_D0: digit = 4'd0;
            ~SEG_D1: digit = 4'd1;
            ~SEG_D2: digit = 4'd2;
            ~SEG_D3: digit = 4'd3;
            ~SEG_D4: digit = 4'd4;
            ~SEG_D5: digit = 4'd5;
            ~SEG_D6: digit = 4'd6;
            ~SEG_D7: digit = 4'd7;
            ~SEG_D8: digit = 4'd8;
            ~SEG_D9: digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_to_bin_seq.sv
// Three-digit 7-segment readback: decode to BCD, then reverse double-dabble
// to binary, one shift per clock. Handshake: start is taken only in IDLE,
// busy marks the shift phase, done pulses one cycle with the result valid.
module seg7_to_bin_seq
    import seg7_to_bin_seq_pkg::*;
#(
    parameter logic SEG_ON = 1'b0,
    parameter int   BIN_W  = BIN_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       seg_hundreds,
    input  logic [6:0]       seg_tens,
    input  logic [6:0]       seg_ones,
    output logic             busy,
    output logic             done,
    output logic [BIN_W-1:0] bin_out,
    output logic             ovf8,
    output logic             err
);

    localparam logic [3:0] LAST = 4'(ITERS - 1);

    logic [3:0] d_hund, d_tens, d_ones;
    logic       v_hund, v_tens, v_ones;

    seg7_decode #(.SEG_ON(SEG_ON)) u_dec_hund (.seg(seg_hundreds), .digit(d_hund), .valid(v_hund));
    seg7_decode #(.SEG_ON(SEG_ON)) u_dec_tens (.seg(seg_tens),     .digit(d_tens), .valid(v_tens));
    seg7_decode #(.SEG_ON(SEG_ON)) u_dec_ones (.seg(seg_ones),     .digit(d_ones), .valid(v_ones));

    state_t             state_q, state_d;
    logic [SHIFT_W-1:0] sr_q, sr_d, sr_shift;
    logic [3:0]         cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;

    assign sr_shift = sr_q >> 1;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (v_hund && v_tens && v_ones) begin
                        sr_d    = {d_hund, d_tens, d_ones, {BIN_W{1'b0}}};
                        cnt_d   = 4'd0;
                        state_d = SHIFT;
                    end else begin
                        bin_d   = '0;
                        ovf_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                sr_d  = {bcd_adjust(sr_shift[SHIFT_W-1:BIN_W]), sr_shift[BIN_W-1:0]};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST) begin
                    bin_d   = sr_shift[BIN_W-1:0];
                    ovf_d   = (sr_shift[BIN_W-1:0] > BIN_W'(255));
                    err_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= 4'd0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

`ifndef SYNTHESIS
    // Every legal 000..999 input must have drained the BCD field completely.
    always_ff @(posedge clk) begin
        if (!reset && state_q == SHIFT && cnt_q == LAST) begin
            assert (sr_d[SHIFT_W-1:BIN_W] == '0)
                else $error("BCD residue left after final shift");
        end
    end
`endif

    assign busy    = (state_q == SHIFT);
    assign done    = (state_q == DONE);
    assign bin_out = bin_q;
    assign ovf8    = ovf_q;
    assign err     = err_q;

endmodule

// File: tb/tb_seg7_to_bin_seq.sv
// Directed bench for seg7_to_bin_seq with a per-cycle reference model.
module tb_seg7_to_bin_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] seg_hundreds = 7'h7f, seg_tens = 7'h7f, seg_ones = 7'h7f;
    logic       busy, done, ovf8, err;
    logic [9:0] bin_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    seg7_to_bin_seq dut (
        .clk(clk), .reset(reset), .start(start),
        .seg_hundreds(seg_hundreds), .seg_tens(seg_tens), .seg_ones(seg_ones),
        .busy(busy), .done(done), .bin_out(bin_out), .ovf8(ovf8), .err(err)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0011000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int tb_dec(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (p == pat(i)) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: phase 0 idle, 1..10 busy cycles, 11 the done cycle
    int         m_phase = 0;
    int         m_pend  = 0;
    logic [9:0] m_bin   = '0;
    logic       m_ovf   = 1'b0;
    logic       m_err   = 1'b0;
    logic [9:0] exp_q[$];

    always @(posedge clk) begin
        int h, t, o;
        if (reset) begin
            m_phase = 0; m_bin = '0; m_ovf = 1'b0; m_err = 1'b0;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: if (start) begin
                    h = tb_dec(seg_hundreds); t = tb_dec(seg_tens); o = tb_dec(seg_ones);
                    if (h < 0 || t < 0 || o < 0) begin
                        m_bin = '0; m_ovf = 1'b0; m_err = 1'b1; m_phase = 11;
                        exp_q.push_back(m_bin);
                    end else begin
                        m_pend = 100 * h + 10 * t + o;
                        m_phase = 1;
                    end
                end
                10: begin
                    m_bin = 10'(m_pend); m_ovf = (m_pend > 255); m_err = 1'b0;
                    m_phase = 11;
                    exp_q.push_back(m_bin);
                end
                11: m_phase = 0;
                default: m_phase = m_phase + 1;
            endcase
        end
    end

    // scoreboard / per-cycle compare
    always @(negedge clk) begin
        logic [9:0] e;
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 10));
            chk("done", 32'(done), 32'(m_phase == 11));
            chk("bin_out", 32'(bin_out), 32'(m_bin));
            chk("ovf8", 32'(ovf8), 32'(m_ovf));
            chk("err", 32'(err), 32'(m_err));
            if (done === 1'b1) begin
                if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("sb_result", 32'(bin_out), 32'(e));
                end
            end
        end
    end

    // driver tasks
    task automatic set_pats(input logic [6:0] h, input logic [6:0] t, input logic [6:0] o);
        seg_hundreds = h; seg_tens = t; seg_ones = o;
    endtask

    // Issues a one-cycle start and reports which cycle after E0 carried done.
    task automatic conv(input logic [6:0] h, input logic [6:0] t, input logic [6:0] o,
                        output int done_cyc, output int busy_cnt);
        done_cyc = -1; busy_cnt = 0;
        @(posedge clk); #2;
        set_pats(h, t, o);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin done_cyc = k; break; end
        end
        if (done_cyc < 0) chk("conv_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int dc, bc, ndone, last, got;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bin", 32'(bin_out), 32'd0);
        chk("rst_ovf8", 32'(ovf8), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;

        // 255
        conv(pat(2), pat(5), pat(5), dc, bc);
        chk("t1_done_cycle", 32'(dc), 32'd11);
        chk("t1_busy_cycles", 32'(bc), 32'd10);
        chk("t1_bin", 32'(bin_out), 32'd255);
        chk("t1_ovf8", 32'(ovf8), 32'd0);
        chk("t1_err", 32'(err), 32'd0);

        // 999 then 000
        conv(pat(9), pat(9), pat(9), dc, bc);
        chk("t2_bin999", 32'(bin_out), 32'h3E7);
        chk("t2_ovf8_999", 32'(ovf8), 32'd1);
        chk("t2_err_999", 32'(err), 32'd0);
        conv(pat(0), pat(0), pat(0), dc, bc);
        chk("t2_bin000", 32'(bin_out), 32'd0);
        chk("t2_ovf8_000", 32'(ovf8), 32'd0);

        // blank tens digit
        conv(pat(1), 7'b1111111, pat(1), dc, bc);
        chk("t3_done_cycle", 32'(dc), 32'd1);
        chk("t3_busy_cycles", 32'(bc), 32'd0);
        chk("t3_bin", 32'(bin_out), 32'd0);
        chk("t3_err", 32'(err), 32'd1);

        // 128 with extra starts and input churn
        @(posedge clk); #2;
        set_pats(pat(1), pat(2), pat(8));
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 14; k++) begin
            start = (k == 3 || k == 10);
            if (k == 2) set_pats(pat(9), pat(9), pat(9));
            if (k == 6) set_pats(pat(4), pat(0), pat(7));
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                chk("t4_done_cycle", 32'(k), 32'd11);
                chk("t4_bin", 32'(bin_out), 32'd128);
            end
            @(posedge clk); #2;
        end
        start = 1'b0;
        chk("t4_done_count", 32'(ndone), 32'd1);

        // reset during 742
        set_pats(pat(7), pat(4), pat(2));
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin @(posedge clk); #2; end
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_busy_after_rst", 32'(busy), 32'd0);
        chk("t5_bin_after_rst", 32'(bin_out), 32'd0);
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("t5_no_done", 32'(ndone), 32'd0);
        conv(pat(7), pat(4), pat(2), dc, bc);
        chk("t5_bin742", 32'(bin_out), 32'd742);
        chk("t5_ovf8", 32'(ovf8), 32'd1);

        // full sweep with start held high
        @(posedge clk); #2;
        set_pats(pat(0), pat(0), pat(0));
        start = 1'b1;
        last = -1;
        for (int n = 0; n < 1000; n++) begin
            got = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (done === 1'b1) begin got = 1; break; end
            end
            if (got == 0) begin
                chk("t6_timeout", 32'd1, 32'd0);
                break;
            end
            chk("t6_bin", 32'(bin_out), 32'(n));
            if (last >= 0) chk("t6_spacing", 32'(cyc - last), 32'd12);
            last = cyc;
            if (n < 999) set_pats(pat((n + 1) / 100), pat(((n + 1) / 10) % 10), pat((n + 1) % 10));
            else start = 1'b0;
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
